// File: rtl/pe_pkg.sv
// Shared definitions for param_systolic_pe: mode encodings and the product-extend /
// saturating-add helpers (the latter is used only when PE_SAT_EN is defined).
package pe_pkg;

    localparam logic PE_MODE_OS = 1'b0;
    localparam logic PE_MODE_PS = 1'b1;

    // Helpers work on a fixed 64-bit carrier; callers keep ACC_W below this width.
    localparam int PE_MAX_W = 64;
    typedef logic [PE_MAX_W-1:0] pe_max_t;

    typedef struct packed {
        pe_max_t sum;
        logic    sat;
    } pe_sum_t;

    function automatic pe_max_t pe_extend(input pe_max_t v, input int unsigned w,
                                          input bit is_signed);
        pe_max_t mask;
        pe_max_t res;
        mask = (pe_max_t'(1) << w) - pe_max_t'(1);
        res  = v & mask;
        if (is_signed && v[w-1]) begin
            res = res | ~mask;
        end
        return res;
    endfunction

    function automatic pe_sum_t pe_sat_add(input pe_max_t a, input pe_max_t b,
                                           input int unsigned w, input bit is_signed);
        pe_sum_t r;
        pe_max_t s;
        pe_max_t lim_hi;
        pe_max_t lim_lo;
        r.sat = 1'b0;
        if (is_signed) begin
            s      = pe_extend(a, w, 1'b1) + pe_extend(b, w, 1'b1);
            lim_hi = (pe_max_t'(1) << (w - 1)) - pe_max_t'(1);
            lim_lo = ~lim_hi;
            if ($signed(s) > $signed(lim_hi)) begin
                r.sum = lim_hi;
                r.sat = 1'b1;
            end else if ($signed(s) < $signed(lim_lo)) begin
                r.sum = lim_lo;
                r.sat = 1'b1;
            end else begin
                r.sum = s;
            end
        end else begin
            s      = pe_extend(a, w, 1'b0) + pe_extend(b, w, 1'b0);
            lim_hi = (pe_max_t'(1) << w) - pe_max_t'(1);
            if (s > lim_hi) begin
                r.sum = lim_hi;
                r.sat = 1'b1;
            end else begin
                r.sum = s;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_systolic_pe_if.sv
// Port bundle of one systolic PE. Optional sat_flag exists only when PE_SAT_EN is defined.
interface param_systolic_pe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    // in_valid qualifies a_in/b_in for this cycle; out_valid is in_valid delayed by one
    // enabled edge alongside a_out/b_out. There is no backpressure: en=0 stalls everything.
    logic              en;
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [ACC_W-1:0]  c_in;
    logic              clr_acc;
    logic              drain_load;
    logic              drain_shift;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic              out_valid;
    logic [ACC_W-1:0]  c_out;
    logic [ACC_W-1:0]  acc_dbg;
`ifdef PE_SAT_EN
    logic              sat_flag;
`endif

    modport slave (
        input  en, mode, in_valid, a_in, b_in, c_in, clr_acc, drain_load, drain_shift,
        output a_out, b_out, out_valid, c_out, acc_dbg
`ifdef PE_SAT_EN
        , sat_flag
`endif
    );

    modport master (
        output en, mode, in_valid, a_in, b_in, c_in, clr_acc, drain_load, drain_shift,
        input  a_out, b_out, out_valid, c_out, acc_dbg
`ifdef PE_SAT_EN
        , sat_flag
`endif
    );
endinterface

// File: rtl/pe_mac_unit.sv
// Combinational multiply, extend-to-accumulator and add (wrapping, or saturating
// when PE_SAT_EN is defined). Shared by the output-stationary and partial-sum paths.
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [ACC_W-1:0]  addend_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sat_o
);
    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] a_x;
    logic [PROD_W-1:0] b_x;
    logic [PROD_W-1:0] prod;
    pe_max_t           prod_ext;

    // Extending the operands first keeps the low PROD_W bits correct for both signednesses.
    assign a_x      = SIGNED ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
    assign b_x      = SIGNED ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
    assign prod     = a_x * b_x;
    assign prod_ext = pe_extend(pe_max_t'(prod), PROD_W, SIGNED);

`ifdef PE_SAT_EN
    pe_sum_t                   res;
    logic [PE_MAX_W-ACC_W-1:0] unused_sum_hi;
    assign res                    = pe_sat_add(prod_ext, pe_max_t'(addend_i), ACC_W, SIGNED);
    assign {unused_sum_hi, sum_o} = res.sum;
    assign sat_o                  = res.sat;
`else
    logic [ACC_W-1:0]          prod_acc;
    logic [PE_MAX_W-ACC_W-1:0] unused_ext_hi;
    assign {unused_ext_hi, prod_acc} = prod_ext;
    assign sum_o                     = prod_acc + addend_i;
    assign sat_o                     = 1'b0;
`endif
endmodule

// File: rtl/param_systolic_pe.sv
// Systolic PE: forwards A east / B south, MACs in output-stationary or partial-sum mode.
// Define PE_SAT_EN for saturating arithmetic and the sticky sat_flag output.
module param_systolic_pe
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter bit SIGNED = 1'b0
) (
    input logic                clk,
    input logic                rst,
    param_systolic_pe_if.slave pe
);
    if (ACC_W < 2 * DATA_W) begin : g_acc_w_min
        $error("param_systolic_pe: ACC_W must be >= 2*DATA_W");
    end
    if (ACC_W >= PE_MAX_W) begin : g_acc_w_max
        $error("param_systolic_pe: ACC_W must be below 64");
    end

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              vld_q, vld_d;
    logic [ACC_W-1:0]  c_q, c_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  mac_addend;
    logic [ACC_W-1:0]  mac_sum;
    logic              mac_sat;

    // PS adds to the upstream sum; OS adds to acc, or to zero when a new accumulation starts.
    assign mac_addend = (pe.mode == PE_MODE_PS) ? pe.c_in : (pe.clr_acc ? '0 : acc_q);

    pe_mac_unit #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .a_i      (pe.a_in),
        .b_i      (pe.b_in),
        .addend_i (mac_addend),
        .sum_o    (mac_sum),
        .sat_o    (mac_sat)
    );

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        vld_d = vld_q;
        c_d   = c_q;
        acc_d = acc_q;
        if (pe.en) begin
            a_d   = pe.a_in;
            b_d   = pe.b_in;
            vld_d = pe.in_valid;
            if (pe.mode == PE_MODE_PS) begin
                c_d = pe.in_valid ? mac_sum : pe.c_in;
            end else begin
                if (pe.in_valid) begin
                    acc_d = mac_sum;
                end else if (pe.clr_acc) begin
                    acc_d = '0;
                end
                // Load exports the pre-update acc and wins over shift.
                if (pe.drain_load) begin
                    c_d = acc_q;
                end else if (pe.drain_shift) begin
                    c_d = pe.c_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            vld_q <= 1'b0;
            c_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            vld_q <= vld_d;
            c_q   <= c_d;
            acc_q <= acc_d;
        end
    end

    assign pe.a_out     = a_q;
    assign pe.b_out     = b_q;
    assign pe.out_valid = vld_q;
    assign pe.c_out     = c_q;
    assign pe.acc_dbg   = acc_q;

`ifdef PE_SAT_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (pe.en) begin
            if (pe.mode == PE_MODE_OS && pe.clr_acc) begin
                sat_d = 1'b0;
            end
            if (pe.in_valid && mac_sat) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign pe.sat_flag = sat_q;
`else
    logic unused_sat;
    assign unused_sat = mac_sat;
`endif
endmodule

// File: tb/tb_param_systolic_pe.sv
// Bench for param_systolic_pe: unsigned/signed PEs with queue scoreboards on out_valid,
// plus a three-PE drain chain and directed c_out / control / reset checks.
module tb_param_systolic_pe;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scoreboard entries: {a_out, b_out, acc_dbg}
    logic [31:0] exp_u_q[$];
    logic [31:0] exp_s_q[$];

    logic [7:0]  va [3] = '{8'h55, 8'h12, 8'h94};
    logic [7:0]  vb [3] = '{8'h33, 8'h2E, 8'h77};
    logic [15:0] eu [3] = '{16'd4335, 16'd5163, 16'h58F7};
    logic [15:0] es [3] = '{16'd4335, 16'd5163, 16'hE1F7};
`ifdef PE_SAT_EN
    logic [15:0] esat [3] = '{16'h3F01, 16'h7E02, 16'h7FFF};
`else
    logic [15:0] esat [3] = '{16'h3F01, 16'h7E02, 16'hBD03};
`endif

    param_systolic_pe_if #(.DATA_W(8), .ACC_W(16)) ifu ();
    param_systolic_pe_if #(.DATA_W(8), .ACC_W(16)) ifs ();
    param_systolic_pe_if #(.DATA_W(8), .ACC_W(16)) ifc0 ();
    param_systolic_pe_if #(.DATA_W(8), .ACC_W(16)) ifc1 ();
    param_systolic_pe_if #(.DATA_W(8), .ACC_W(16)) ifc2 ();

    assign ifc1.c_in = ifc0.c_out;
    assign ifc2.c_in = ifc1.c_out;

    param_systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0)) dut_u  (.clk(clk), .rst(rst), .pe(ifu));
    param_systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) dut_s  (.clk(clk), .rst(rst), .pe(ifs));
    param_systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0)) dut_c0 (.clk(clk), .rst(rst), .pe(ifc0));
    param_systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0)) dut_c1 (.clk(clk), .rst(rst), .pe(ifc1));
    param_systolic_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b0)) dut_c2 (.clk(clk), .rst(rst), .pe(ifc2));

`define PE_IDLE(ifx) begin ifx.en = 1'b1; ifx.mode = 1'b0; ifx.in_valid = 1'b0; ifx.a_in = '0; ifx.b_in = '0; ifx.clr_acc = 1'b0; ifx.drain_load = 1'b0; ifx.drain_shift = 1'b0; end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chain_ctl(input logic load, input logic shift);
        ifc0.drain_load = load; ifc1.drain_load = load; ifc2.drain_load = load;
        ifc0.drain_shift = shift; ifc1.drain_shift = shift; ifc2.drain_shift = shift;
    endtask

    // Monitors: pop and compare whenever a PE presents a fresh out_valid.
    initial begin : mon_u
        logic fresh;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            fresh = ifu.en & ~rst;
            @(negedge clk);
            if (ifu.out_valid && fresh) begin
                tests++;
                if (exp_u_q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_u unexpected output got=0x%0h", {ifu.a_out, ifu.b_out, ifu.acc_dbg});
                end else begin
                    e = exp_u_q.pop_front();
                    if ({ifu.a_out, ifu.b_out, ifu.acc_dbg} !== e) begin
                        fails++;
                        $display("FAIL mon_u got=0x%0h exp=0x%0h", {ifu.a_out, ifu.b_out, ifu.acc_dbg}, e);
                    end
                end
            end
        end
    end

    initial begin : mon_s
        logic fresh;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            fresh = ifs.en & ~rst;
            @(negedge clk);
            if (ifs.out_valid && fresh) begin
                tests++;
                if (exp_s_q.size() == 0) begin
                    fails++;
                    $display("FAIL mon_s unexpected output got=0x%0h", {ifs.a_out, ifs.b_out, ifs.acc_dbg});
                end else begin
                    e = exp_s_q.pop_front();
                    if ({ifs.a_out, ifs.b_out, ifs.acc_dbg} !== e) begin
                        fails++;
                        $display("FAIL mon_s got=0x%0h exp=0x%0h", {ifs.a_out, ifs.b_out, ifs.acc_dbg}, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1;
        `PE_IDLE(ifu)
        `PE_IDLE(ifs)
        `PE_IDLE(ifc0)
        `PE_IDLE(ifc1)
        `PE_IDLE(ifc2)
        ifu.c_in = '0; ifs.c_in = '0; ifc0.c_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out", ifu.a_out, 0);
        chk("rst_b_out", ifu.b_out, 0);
        chk("rst_c_out", ifu.c_out, 0);
        chk("rst_acc", ifu.acc_dbg, 0);
        chk("rst_out_valid", ifu.out_valid, 0);
`ifdef PE_SAT_EN
        chk("rst_sat_flag", ifs.sat_flag, 0);
`endif
        rst = 1'b0;
        step();

        // OS accumulation, unsigned and signed side by side
        for (int i = 0; i < 3; i++) begin
            ifu.a_in = va[i]; ifu.b_in = vb[i]; ifu.in_valid = 1'b1; ifu.clr_acc = (i == 0);
            ifs.a_in = va[i]; ifs.b_in = vb[i]; ifs.in_valid = 1'b1; ifs.clr_acc = (i == 0);
            exp_u_q.push_back({va[i], vb[i], eu[i]});
            exp_s_q.push_back({va[i], vb[i], es[i]});
            step();
        end
        ifu.in_valid = 1'b0; ifu.clr_acc = 1'b0; ifu.drain_load = 1'b1;
        ifs.in_valid = 1'b0; ifs.clr_acc = 1'b0; ifs.drain_load = 1'b1;
        step();
        chk("os_u_drain", ifu.c_out, 16'h58F7);
        chk("os_s_drain", ifs.c_out, 16'hE1F7);
        chk("os_u_acc_hold", ifu.acc_dbg, 16'h58F7);
        ifu.drain_load = 1'b0;
        ifs.drain_load = 1'b0;

        // Signed overflow: wraps, or clamps with sat_flag
        for (int i = 0; i < 3; i++) begin
            ifs.a_in = 8'h7F; ifs.b_in = 8'h7F; ifs.in_valid = 1'b1; ifs.clr_acc = (i == 0);
            exp_s_q.push_back({8'h7F, 8'h7F, esat[i]});
            step();
        end
`ifdef PE_SAT_EN
        chk("sat_flag_set", ifs.sat_flag, 1);
`endif
        ifs.in_valid = 1'b0; ifs.clr_acc = 1'b1;
        step();
        chk("clr_acc_zero", ifs.acc_dbg, 0);
`ifdef PE_SAT_EN
        chk("sat_flag_clr", ifs.sat_flag, 0);
`endif
        ifs.clr_acc = 1'b0;

        // PS mode: OS controls are ignored, acc is untouched
        ifu.mode = 1'b1; ifu.c_in = 16'd4; ifu.a_in = 8'd3; ifu.b_in = 8'd5; ifu.in_valid = 1'b1;
        ifu.clr_acc = 1'b1; ifu.drain_load = 1'b1; ifu.drain_shift = 1'b1;
        exp_u_q.push_back({8'd3, 8'd5, 16'h58F7});
        step();
        chk("ps_mac", ifu.c_out, 19);
        ifu.in_valid = 1'b0;
        step();
        chk("ps_pass", ifu.c_out, 4);
        chk("ps_acc_hold", ifu.acc_dbg, 16'h58F7);
        ifu.mode = 1'b0; ifu.clr_acc = 1'b0; ifu.drain_load = 1'b0; ifu.drain_shift = 1'b0;
        ifu.c_in = '0;

        // Drain chain: PE2 is the column end
        ifc0.a_in = 8'd10; ifc1.a_in = 8'd20; ifc2.a_in = 8'd30;
        ifc0.b_in = 8'd1;  ifc1.b_in = 8'd1;  ifc2.b_in = 8'd1;
        ifc0.in_valid = 1'b1; ifc1.in_valid = 1'b1; ifc2.in_valid = 1'b1;
        ifc0.clr_acc = 1'b1; ifc1.clr_acc = 1'b1; ifc2.clr_acc = 1'b1;
        step();
        ifc0.in_valid = 1'b0; ifc1.in_valid = 1'b0; ifc2.in_valid = 1'b0;
        ifc0.clr_acc = 1'b0; ifc1.clr_acc = 1'b0; ifc2.clr_acc = 1'b0;
        chk("chain_acc0", ifc0.acc_dbg, 10);
        chk("chain_acc1", ifc1.acc_dbg, 20);
        chk("chain_acc2", ifc2.acc_dbg, 30);
        chain_ctl(1'b1, 1'b0);
        step();
        chk("chain_load", ifc2.c_out, 30);
        chain_ctl(1'b0, 1'b1);
        step();
        chk("chain_shift1", ifc2.c_out, 20);
        step();
        chk("chain_shift2", ifc2.c_out, 10);
        chain_ctl(1'b1, 1'b1);
        step();
        chk("chain_load_wins", ifc2.c_out, 30);
        chain_ctl(1'b0, 1'b0);

        // en=0 freezes every output while inputs toggle
        ifu.a_in = 8'd2; ifu.b_in = 8'd3; ifu.in_valid = 1'b1; ifu.clr_acc = 1'b1;
        exp_u_q.push_back({8'd2, 8'd3, 16'd6});
        step();
        ifu.a_in = 8'd4; ifu.b_in = 8'd5; ifu.clr_acc = 1'b0;
        exp_u_q.push_back({8'd4, 8'd5, 16'd26});
        step();
        ifu.en = 1'b0; ifu.a_in = 8'hAA; ifu.b_in = 8'hBB; ifu.clr_acc = 1'b1;
        ifu.drain_load = 1'b1; ifu.mode = 1'b1; ifu.c_in = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en0_a_out", ifu.a_out, 4);
            chk("en0_b_out", ifu.b_out, 5);
            chk("en0_out_valid", ifu.out_valid, 1);
            chk("en0_acc", ifu.acc_dbg, 26);
            chk("en0_c_out", ifu.c_out, 4);
        end
        ifu.en = 1'b1; ifu.in_valid = 1'b0; ifu.clr_acc = 1'b0; ifu.drain_load = 1'b0;
        ifu.mode = 1'b0; ifu.c_in = '0;
        step();

        // Asynchronous reset between edges, mid-accumulation
        ifu.a_in = 8'd1; ifu.b_in = 8'd1; ifu.in_valid = 1'b1;
        exp_u_q.push_back({8'd1, 8'd1, 16'd27});
        step();
        ifu.in_valid = 1'b0;
        #6;
        rst = 1'b1;
        #1;
        chk("arst_a_out", ifu.a_out, 0);
        chk("arst_acc", ifu.acc_dbg, 0);
        chk("arst_out_valid", ifu.out_valid, 0);
        chk("arst_c_out", ifu.c_out, 0);
        chk("arst_chain_c_out", ifc2.c_out, 0);
        #1;
        rst = 1'b0;
        step();
        chk("post_rst_acc", ifu.acc_dbg, 0);

        repeat (2) step();
        chk("exp_u_q_empty", exp_u_q.size(), 0);
        chk("exp_s_q_empty", exp_s_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
